// File: rtl/multicycle_controller.sv
// Control unit for a multicycle RV32I datapath: Moore sequencing FSM with
// combinational ALU-control and immediate-format decoders.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [1:0]         ImmSrc,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       pc_update, branch;
    logic [1:0] alu_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = FETCH;
        illegal_d = 1'b0;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    // Moore outputs; only the fetch handshake and branch condition look at inputs.
    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        alu_op    = 2'b00;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        case (state_q)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                pc_update = mem_ready;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            ALUWB:    RegWrite = 1'b1;
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite = pc_update | (branch & Zero);
    assign illegal = illegal_q;
    assign state   = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-cycle vector table walks
// every instruction class, plus hand sequences for reset corner cases.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,illegal}
    logic [16:0] act;
    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};

    function automatic logic [16:0] c(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] alu, input logic [1:0] imm,
                                      input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill};
    endfunction

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] ctl;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic mr, input logic [3:0] st,
                       input logic [16:0] ctl, input string name);
        vec_t v;
        v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = mr; v.st = st; v.ctl = ctl; v.name = name;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] st_exp, input logic [16:0] ctl_exp);
        checks++;
        if (state !== st_exp || act !== ctl_exp) begin
            failures++;
            $display("FAIL %s: state=%0d ctl=%b, expected state=%0d ctl=%b",
                     name, state, act, st_exp, ctl_exp);
        end
    endtask

    // Common output patterns (imm and funct-dependent fields are filled per row).
    function automatic logic [16:0] f_fetch(input logic mr, input logic [1:0] imm, input logic ill);
        return c(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, ill);
    endfunction
    function automatic logic [16:0] f_dec(input logic [1:0] imm);
        return c(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0);
    endfunction
    function automatic logic [16:0] f_aluwb(input logic [1:0] imm);
        return c(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0);
    endfunction

    task automatic apply(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input logic mr);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; mem_ready = mr;
    endtask

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111,
                           BAD = 7'b1111111;

    initial begin
        rst = 1'b1;
        apply(7'b0, 3'b0, 1'b0, 1'b0, 1'b0);
        #3;
        check("reset_state", 4'd0, f_fetch(0, 2'b00, 0));
        @(posedge clk); #1;
        check("reset_hold", 4'd0, f_fetch(0, 2'b00, 0));
        rst = 1'b0;

        // lw, no stalls: 0,1,2,3,4
        row(LW, 0, 0, 0, 1, 0, f_fetch(1, 2'b00, 0), "lw_fetch");
        row(LW, 0, 0, 0, 1, 1, f_dec(2'b00), "lw_decode");
        row(LW, 0, 0, 0, 1, 2, c(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0), "lw_memadr");
        row(LW, 0, 0, 0, 1, 3, c(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0), "lw_memread");
        row(LW, 0, 0, 0, 1, 4, c(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,2'b00,0), "lw_memwb");
        // sw with three stall cycles in MEMWRITE
        row(SW, 0, 0, 0, 1, 0, f_fetch(1, 2'b01, 0), "sw_fetch");
        row(SW, 0, 0, 0, 1, 1, f_dec(2'b01), "sw_decode");
        row(SW, 0, 0, 0, 1, 2, c(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0), "sw_memadr");
        for (int i = 0; i < 3; i++)
            row(SW, 0, 0, 0, 0, 5, c(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0), "sw_memwrite_stall");
        row(SW, 0, 0, 0, 1, 5, c(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0), "sw_memwrite_done");
        // R sub
        row(RT, 3'b000, 1, 0, 1, 0, f_fetch(1, 2'b00, 0), "sub_fetch");
        row(RT, 3'b000, 1, 0, 1, 1, f_dec(2'b00), "sub_decode");
        row(RT, 3'b000, 1, 0, 1, 6, c(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0), "sub_execr");
        row(RT, 3'b000, 1, 0, 1, 7, f_aluwb(2'b00), "sub_aluwb");
        // addi with funct7b5=1 must still add
        row(IT, 3'b000, 1, 0, 1, 0, f_fetch(1, 2'b00, 0), "addi_fetch");
        row(IT, 3'b000, 1, 0, 1, 1, f_dec(2'b00), "addi_decode");
        row(IT, 3'b000, 1, 0, 1, 8, c(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0), "addi_execi");
        row(IT, 3'b000, 1, 0, 1, 7, f_aluwb(2'b00), "addi_aluwb");
        // slt, ori, and
        row(RT, 3'b010, 0, 0, 1, 0, f_fetch(1, 2'b00, 0), "slt_fetch");
        row(RT, 3'b010, 0, 0, 1, 1, f_dec(2'b00), "slt_decode");
        row(RT, 3'b010, 0, 0, 1, 6, c(0,0,0,0,0,2'b00,2'b10,2'b00,3'b101,2'b00,0), "slt_execr");
        row(RT, 3'b010, 0, 0, 1, 7, f_aluwb(2'b00), "slt_aluwb");
        row(IT, 3'b110, 0, 0, 1, 0, f_fetch(1, 2'b00, 0), "ori_fetch");
        row(IT, 3'b110, 0, 0, 1, 1, f_dec(2'b00), "ori_decode");
        row(IT, 3'b110, 0, 0, 1, 8, c(0,0,0,0,0,2'b00,2'b10,2'b01,3'b011,2'b00,0), "ori_execi");
        row(IT, 3'b110, 0, 0, 1, 7, f_aluwb(2'b00), "ori_aluwb");
        row(RT, 3'b111, 0, 0, 1, 0, f_fetch(1, 2'b00, 0), "and_fetch");
        row(RT, 3'b111, 0, 0, 1, 1, f_dec(2'b00), "and_decode");
        row(RT, 3'b111, 0, 0, 1, 6, c(0,0,0,0,0,2'b00,2'b10,2'b00,3'b010,2'b00,0), "and_execr");
        row(RT, 3'b111, 0, 0, 1, 7, f_aluwb(2'b00), "and_aluwb");
        // beq taken then not taken
        row(BQ, 0, 0, 1, 1, 0, f_fetch(1, 2'b10, 0), "beqt_fetch");
        row(BQ, 0, 0, 1, 1, 1, f_dec(2'b10), "beqt_decode");
        row(BQ, 0, 0, 1, 1, 10, c(1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0), "beqt_beq");
        row(BQ, 0, 0, 0, 1, 0, f_fetch(1, 2'b10, 0), "beqn_fetch");
        row(BQ, 0, 0, 0, 1, 1, f_dec(2'b10), "beqn_decode");
        row(BQ, 0, 0, 0, 1, 10, c(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0), "beqn_beq");
        // jal
        row(JL, 0, 0, 0, 1, 0, f_fetch(1, 2'b11, 0), "jal_fetch");
        row(JL, 0, 0, 0, 1, 1, f_dec(2'b11), "jal_decode");
        row(JL, 0, 0, 0, 1, 9, c(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b11,0), "jal_jal");
        row(JL, 0, 0, 0, 1, 7, f_aluwb(2'b11), "jal_aluwb");
        // illegal op: pulse in the FETCH after DECODE only; FETCH stalls meanwhile
        row(BAD, 0, 0, 0, 1, 0, f_fetch(1, 2'b00, 0), "ill_fetch");
        row(BAD, 0, 0, 0, 1, 1, f_dec(2'b00), "ill_decode");
        row(BAD, 0, 0, 0, 0, 0, f_fetch(0, 2'b00, 1), "ill_pulse");
        row(BAD, 0, 0, 0, 0, 0, f_fetch(0, 2'b00, 0), "ill_cleared");

        foreach (tbl[i]) begin
            apply(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].mr);
            #2;
            check(tbl[i].name, tbl[i].st, tbl[i].ctl);
            @(posedge clk); #1;
        end

        // Async reset in MEMWB: FETCH immediately, no RegWrite.
        apply(LW, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        check("rstwb_pre", 4'd4, c(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,2'b00,0));
        #2 rst = 1'b1;
        #1;
        check("rstwb_async", 4'd0, f_fetch(1, 2'b00, 0));
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("rstwb_after", 4'd0, f_fetch(0, 2'b00, 0));

        // Async reset during a stalled MEMWRITE: MemWrite drops at once.
        apply(SW, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        #1;
        check("rstmw_pre", 4'd5, c(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0));
        rst = 1'b1;
        #1;
        check("rstmw_async", 4'd0, f_fetch(0, 2'b01, 0));
        @(posedge clk); #1;
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM plus combinational ALU/immediate decoders that sequence a multicycle RV32I datapath.
- The datapath shares one ALU and one unified instruction/data memory.
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.
- Memory accesses stall on a ready handshake from the memory.

Parameters:
- STATE_W, 4, width of the debug state output (fixed encoding below; must be ≥4).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- op  input  7  Instr[6:0] from the instruction register.
- funct3  input  3  Instr[14:12].
- funct7b5  input  1  Instr[30].
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- PCWrite  output  1  PC register load enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register (and OldPC) load enable.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  output  2  00 = rs2, 01 = ImmExt, 10 = constant 4.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc  output  2  00 I-type, 01 S-type, 10 B-type, 11 J-type.
- illegal  output  1  one-cycle pulse: unsupported opcode was decoded.
- state  output  STATE_W  current state, for debug.

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10.
- The state register and the illegal flop are the only sequential elements. The async reset puts the state in FETCH and clears illegal.
- Outputs are combinational from state (Moore), except: PCWrite and IRWrite are gated by mem_ready, and PCWrite also uses Zero.
- Any output not listed for a state is 0. ALUOp (internal) is 00 by default.
- Per-state outputs and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=mem_ready; PCUpdate=mem_ready. Go to DECODE if mem_ready, else stay in FETCH.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target). Next state by op:
    - 0000011 → MEMADR
    - 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other op → FETCH, and illegal goes high the next cycle for one cycle.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Go to MEMWB if mem_ready, else stay.
  - MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 (held high until accepted). Go to FETCH if mem_ready, else stay.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Go to FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Go to ALUWB.
  - Unused encodings 11–15: all outputs 0; next state FETCH.
- PCWrite = PCUpdate | (Branch & Zero).
- ALU decoder:
  - ALUOp 00 → 000; ALUOp 01 → 001.
  - ALUOp 10, by funct3:
    - 000 → 001 if (op[5] & funct7b5), else 000
    - 010 → 101
    - 110 → 011
    - 111 → 010
    - anything else → 000
  - ALUOp 11 → 000.
- ImmSrc is decoded from op in every state:
  - 0000011 or 0010011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - otherwise 00
- Latency with mem_ready tied to 1 (cycles from FETCH to the next FETCH): lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal op 2. Each cycle mem_ready is low adds 1 cycle in FETCH, MEMREAD or MEMWRITE.
- Reset asserted mid-instruction: state becomes FETCH immediately (asynchronously); no RegWrite or MemWrite is issued after the reset edge. Outputs while rst is high are the FETCH values gated by mem_ready.
- Reset values with mem_ready=0: all enables 0; ALUSrcB=10, ResultSrc=10, all other muxes 00; ALUControl=000; illegal=0; state=0.

Test Plan:
- Reset: rst=1, mem_ready=0 → state=0, PCWrite=IRWrite=RegWrite=MemWrite=0, illegal=0. Assert rst in MEMWB → state=0 in the same cycle, RegWrite=0.
- lw (op=0000011), mem_ready=1 → state sequence 0,1,2,3,4,0. ALUSrcA=10 and ALUSrcB=01 in MEMADR. RegWrite=1 with ResultSrc=01 only in state 4.
- sw (op=0100011), mem_ready=0 for 3 cycles in MEMWRITE → MemWrite=1 and AdrSrc=1 held for 4 cycles, then state=0. ImmSrc=01 throughout.
- R-type sub (op=0110011, funct3=000, funct7b5=1) → ALUControl=001 in EXECR. Same with op=0010011 → ALUControl=000. funct3=010 → 101, 110 → 011, 111 → 010.
- beq (op=1100011): Zero=1 in BEQ → PCWrite=1 and ALUControl=001; Zero=0 → PCWrite=0. Sequence 0,1,10,0 in both cases.
- jal (op=1101111) → 0,1,9,7,0. In JAL: PCWrite=1, ALUSrcA=01, ALUSrcB=10, ImmSrc=11. Illegal op=1111111 → 0,1,0 with illegal=1 in the second FETCH cycle only.
